// File: rtl/resp_chk_pkg.sv
// resp_chk_pkg: shared widths, FSM state type and MISR constants for resp_capture_checker
package resp_chk_pkg;
  localparam int PAT_W_DEF = 4;
  localparam int NUM_PAT_DEF = 16;
  localparam logic [7:0] MISR_POLY = 8'h1D;
  localparam logic [7:0] MISR_SEED = 8'hFF;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_REPORT} state_t;
endpackage

// File: rtl/resp_misr.sv
// resp_misr: 8-bit Galois MISR (x^8+x^4+x^3+x^2+1) with seed load and fold enable
module resp_misr
  import resp_chk_pkg::*;
#(
  parameter int DW = 5
) (
  input  logic          CK,
  input  logic          reset,
  input  logic          i_seed,
  input  logic          i_en,
  input  logic [DW-1:0] i_data,
  output logic [7:0]    o_sig
);
  logic [7:0] r_sig;
  always_ff @(posedge CK)
    if (reset || i_seed) r_sig <= MISR_SEED;
    else if (i_en) r_sig <= {r_sig[6:0], 1'b0} ^ (r_sig[7] ? MISR_POLY : 8'h00) ^ 8'(i_data);
  assign o_sig = r_sig;
endmodule

// File: rtl/resp_capture_checker.sv
// resp_capture_checker: compares captured responses to a golden vector per run; TROJAN_MISR_EN adds the sig MISR output
module resp_capture_checker
  import resp_chk_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int NUM_PAT = NUM_PAT_DEF
) (
  input  logic               CK,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic               gold_we,
  input  logic [NUM_PAT-1:0] gold_data,
  input  logic               s_valid,
  input  logic [PAT_W-1:0]   s_pat,
  input  logic               s_resp,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [PAT_W:0]     err_cnt,
  output logic [PAT_W-1:0]   first_fail,
  output logic               dup_err
`ifdef TROJAN_MISR_EN
  ,
  output logic [7:0]         sig
`endif
);
  state_t r_state;
  logic [NUM_PAT-1:0] r_gold, r_seen;
  logic [PAT_W:0] r_err_cnt;
  logic [PAT_W-1:0] r_first_fail;
  logic r_dup;
  logic w_start, w_acc, w_new, w_mis, w_full;
  logic [NUM_PAT-1:0] w_seen_nx;
  assign w_start = start && r_state != S_RUN;
  assign w_acc = r_state == S_RUN && s_valid && !abort;
  assign w_new = w_acc && !r_seen[s_pat];
  assign w_mis = w_new && s_resp != r_gold[s_pat];
  assign w_seen_nx = r_seen | (NUM_PAT'(1) << s_pat);
  assign w_full = &w_seen_nx;
  always_ff @(posedge CK)
    if (reset) begin
      r_state <= S_IDLE;
      r_gold <= '0;
      r_seen <= '0;
      r_err_cnt <= '0;
      r_first_fail <= '0;
      r_dup <= 1'b0;
    end else begin
      if (gold_we && !start && r_state != S_RUN) r_gold <= gold_data;
      if (w_start) begin
        r_state <= S_RUN;
        r_seen <= '0;
        r_err_cnt <= '0;
        r_first_fail <= '0;
        r_dup <= 1'b0;
      end else if (abort && r_state != S_IDLE) r_state <= S_IDLE;
      else if (w_acc) begin
        if (!w_new) r_dup <= 1'b1;
        else begin
          r_seen <= w_seen_nx;
          if (w_mis && r_err_cnt < (PAT_W+1)'(NUM_PAT)) r_err_cnt <= r_err_cnt + 1'b1;
          if (w_mis && r_err_cnt == '0) r_first_fail <= s_pat;
          if (w_full) r_state <= S_REPORT;
        end
      end
    end
  assign busy = r_state == S_RUN;
  assign done = r_state == S_REPORT;
  assign pass = done && r_err_cnt == '0 && !r_dup;
  assign err_cnt = r_err_cnt;
  assign first_fail = r_first_fail;
  assign dup_err = r_dup;
`ifdef TROJAN_MISR_EN
  resp_misr #(.DW(PAT_W + 1)) u_misr (
    .CK     (CK),
    .reset  (reset),
    .i_seed (w_start),
    .i_en   (w_new),
    .i_data ({s_pat, s_resp}),
    .o_sig  (sig)
  );
`endif
endmodule
